// File: rtl/fc_pkg.sv
// Shared sizes, the default data word type and the writeback FSM state encoding.
package fc_pkg;

  localparam int WORD_SIZE    = 16;
  localparam int OP_SIZE      = 10;
  localparam int ADDRESS_SIZE = 16;

  typedef logic signed [WORD_SIZE-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLASS = 2'd2,
    DONE  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/fc_argmax_tracker.sv
// Running signed maximum over a stream of words; reports the index of the first maximum.
module fc_argmax_tracker #(
  parameter int WORD_SIZE = 16,
  parameter int OP_SIZE   = 10,
  parameter int IDX_W     = $clog2(OP_SIZE)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_valid,
  input  logic [WORD_SIZE-1:0] i_data,
  output logic [IDX_W-1:0]     o_idx
);

  localparam int CNT_W = $clog2(OP_SIZE + 1);

  logic signed [WORD_SIZE-1:0] r_max;
  logic [CNT_W-1:0]            r_cnt;
  logic [IDX_W-1:0]            r_idx;

  // Strict '>' keeps the earliest index when values tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_max <= '0;
      r_cnt <= '0;
      r_idx <= '0;
    end else if (i_clear) begin
      r_max <= '0;
      r_cnt <= '0;
      r_idx <= '0;
    end else if (i_valid) begin
      if ((r_cnt == '0) || ($signed(i_data) > r_max)) begin
        r_max <= $signed(i_data);
        r_idx <= r_cnt[IDX_W-1:0];
      end
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_idx = r_idx;

endmodule

// File: rtl/fc_result_writeback.sv
// Snapshots the FC output vector on fc_done and streams it word-by-word into RAM.
// Optional argmax class write is enabled with the FC_WB_ARGMAX_EN macro.
// Handshake: a word transfers on a cycle where ram_we && ram_ready; while ram_we is
// high and ram_ready is low, ram_addr/ram_wdata stay stable and ram_we is never retracted.
module fc_result_writeback #(
  parameter int WORD_SIZE    = fc_pkg::WORD_SIZE,
  parameter int OP_SIZE      = fc_pkg::OP_SIZE,
  parameter int ADDRESS_SIZE = fc_pkg::ADDRESS_SIZE,
  parameter int IDX_W        = $clog2(OP_SIZE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fc_done,
  input  logic [WORD_SIZE-1:0]    fc_result [OP_SIZE-1:0],
  input  logic [ADDRESS_SIZE-1:0] base_addr,
  input  logic                    ram_ready,
  output logic                    ram_we,
  output logic [ADDRESS_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0]    ram_wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun,
  output logic [IDX_W-1:0]        class_idx,
  output fc_pkg::wb_state_e       dbg_state
);

  import fc_pkg::*;

  wb_state_e               r_state;
  wb_state_e               w_next;
  logic [WORD_SIZE-1:0]    r_buf [OP_SIZE-1:0];
  logic [ADDRESS_SIZE-1:0] r_base;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_overrun;
  logic [IDX_W-1:0]        w_class_idx;
  logic                    w_capture;
  logic                    w_last;
  logic                    w_word_xfer;

  assign w_capture   = (r_state == IDLE) && fc_done;
  assign w_last      = (r_idx == IDX_W'(OP_SIZE - 1));
  assign w_word_xfer = (r_state == WRITE) && ram_ready;

  always_comb begin
    w_next    = r_state;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (fc_done) w_next = WRITE;
      end
      WRITE: begin
        ram_we    = 1'b1;
        ram_addr  = r_base + ADDRESS_SIZE'(r_idx);
        ram_wdata = r_buf[r_idx];
        busy      = 1'b1;
`ifdef FC_WB_ARGMAX_EN
        if (ram_ready && w_last) w_next = CLASS;
`else
        if (ram_ready && w_last) w_next = DONE;
`endif
      end
      CLASS: begin
        ram_we    = 1'b1;
        ram_addr  = r_base + ADDRESS_SIZE'(OP_SIZE);
        ram_wdata = WORD_SIZE'(w_class_idx);
        busy      = 1'b1;
        if (ram_ready) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // A fc_done outside IDLE (including the DONE cycle) only flags overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_base    <= '0;
      r_idx     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_base    <= base_addr;
        r_idx     <= '0;
        r_overrun <= 1'b0;
      end else begin
        if (fc_done) r_overrun <= 1'b1;
        if (w_word_xfer) r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < OP_SIZE; i++) r_buf[i] <= fc_result[i];
    end
  end

`ifdef FC_WB_ARGMAX_EN
  fc_argmax_tracker #(
    .WORD_SIZE (WORD_SIZE),
    .OP_SIZE   (OP_SIZE),
    .IDX_W     (IDX_W)
  ) u_argmax (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_clear (w_capture),
    .i_valid (w_word_xfer),
    .i_data  (r_buf[r_idx]),
    .o_idx   (w_class_idx)
  );
`else
  assign w_class_idx = '0;
`endif

  assign class_idx = w_class_idx;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fc_result_writeback.sv
// Self-checking bench for fc_result_writeback: directed table, reset corner and random traffic
// against a queue-based write model.
module tb_fc_result_writeback;
  import fc_pkg::*;

  localparam int AW = ADDRESS_SIZE;
  localparam int WW = WORD_SIZE;
  localparam int IW = $clog2(OP_SIZE);
`ifdef FC_WB_ARGMAX_EN
  localparam int ARG_EXTRA = 1;
`else
  localparam int ARG_EXTRA = 0;
`endif

  // clock / reset
  logic          clk = 1'b0;
  logic          reset;
  logic          fc_done;
  logic [WW-1:0] fc_result [OP_SIZE-1:0];
  logic [AW-1:0] base_addr;
  logic          ram_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [WW-1:0] ram_wdata;
  logic          busy;
  logic          done;
  logic          overrun;
  logic [IW-1:0] class_idx;
  wb_state_e     dbg_state;

  always #5 clk = ~clk;

  fc_result_writeback dut (
    .clk       (clk),
    .reset     (reset),
    .fc_done   (fc_done),
    .fc_result (fc_result),
    .base_addr (base_addr),
    .ram_ready (ram_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun),
    .class_idx (class_idx),
    .dbg_state (dbg_state)
  );

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [AW+WW-1:0] exp_q[$];

  typedef struct {
    logic [AW-1:0] base;
    word_t         vals [OP_SIZE];
    int            stall_idx;
    int            stall_len;
    int            ov_cycle;
    bit            ov_in_done;
    int            exp_done;
    int            exp_class;
    bit            exp_ovr;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_argmax(input word_t v [OP_SIZE]);
    int best;
    best = 0;
    for (int i = 1; i < OP_SIZE; i++) if (v[i] > v[best]) best = i;
    return best;
  endfunction

  function automatic void model_push(input logic [AW-1:0] base, input word_t v [OP_SIZE]);
    for (int i = 0; i < OP_SIZE; i++) exp_q.push_back({AW'(base + AW'(i)), WW'(v[i])});
    if (ARG_EXTRA == 1) exp_q.push_back({AW'(base + AW'(OP_SIZE)), WW'(model_argmax(v))});
  endfunction

  task automatic pop_chk(input string name);
    logic [AW+WW-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: unexpected write addr 0x%0h data 0x%0h, none required", name, ram_addr, ram_wdata);
    end else begin
      e = exp_q.pop_front();
      chk(name, 32'({ram_addr, ram_wdata}), 32'(e));
    end
  endtask

  // driver: one full capture + writeback, checking every accepted write on the fly
  task automatic run_op(input logic [AW-1:0] base, input word_t vals [OP_SIZE],
                        input int stall_idx, input int stall_len, input bit rnd_ready,
                        input int ov_cycle, input int ov_done_cyc,
                        output int done_cyc, output int nwr, output int nstall, output int first_cyc);
    logic [AW-1:0] h_addr;
    logic [WW-1:0] h_data;
    bit            prev_hold;
    int            stalled;
    fc_done   = 1'b1;
    base_addr = base;
    ram_ready = 1'b1;
    for (int i = 0; i < OP_SIZE; i++) fc_result[i] = vals[i];
    model_push(base, vals);
    done_cyc  = -1;
    nwr       = 0;
    nstall    = 0;
    first_cyc = -1;
    stalled   = 0;
    prev_hold = 1'b0;
    h_addr    = '0;
    h_data    = '0;
    @(negedge clk);
    chk("busy_before_capture", 32'(busy), 32'd0);
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(posedge clk);
      #1;
      fc_done = (cyc == ov_cycle) || (cyc == ov_done_cyc);
      if (fc_done) begin
        base_addr = AW'($urandom);
        for (int i = 0; i < OP_SIZE; i++) fc_result[i] = WW'($urandom);
      end
      if (rnd_ready) ram_ready = ($urandom_range(0, 3) != 0);
      else if (nwr == stall_idx && stalled < stall_len) begin
        ram_ready = 1'b0;
        stalled++;
      end else ram_ready = 1'b1;
      @(negedge clk);
      if (cyc == 1) chk("overrun_cleared_on_capture", 32'(overrun), 32'd0);
      if (prev_hold) begin
        chk("hold_we", 32'(ram_we), 32'd1);
        chk("hold_addr", 32'(ram_addr), 32'(h_addr));
        chk("hold_data", 32'(ram_wdata), 32'(h_data));
      end
      prev_hold = ram_we && !ram_ready;
      h_addr    = ram_addr;
      h_data    = ram_wdata;
      if (prev_hold) nstall++;
      if (ram_we && ram_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        pop_chk("write_addr_data");
        nwr++;
      end
      if (done) begin
        done_cyc = cyc;
        chk("done_busy_low", 32'(busy), 32'd0);
        chk("done_we_low", 32'(ram_we), 32'd0);
        break;
      end
      chk("busy_during_op", 32'(busy), 32'd1);
    end
    if (done_cyc < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: no done pulse within 80 cycles, wanted one");
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    fc_done   = 1'b0;
    ram_ready = 1'b1;
  endtask

  task automatic idle_cycles(input int n, input bit exp_ovr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_we", 32'(ram_we), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_overrun", 32'(overrun), 32'(exp_ovr));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    dc, nw, ns, fcy, ecls;
    int    av [OP_SIZE];
    word_t rv [OP_SIZE];
    logic [AW-1:0] rbase;

    reset     = 1'b1;
    fc_done   = 1'b0;
    ram_ready = 1'b1;
    base_addr = '0;
    for (int i = 0; i < OP_SIZE; i++) fc_result[i] = '0;
    @(negedge clk);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_class", 32'(class_idx), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_cycles(1, 1'b0);

    // directed vector table
    av = '{-3, 7, 2, 7, -8, 0, 1, 1, 0, 5};
    for (int k = 0; k < 6; k++) begin
      tbl[k].base = 16'h0100;
      for (int i = 0; i < OP_SIZE; i++) tbl[k].vals[i] = word_t'(i + 1);
      tbl[k].stall_idx  = -1;
      tbl[k].stall_len  = 0;
      tbl[k].ov_cycle   = -1;
      tbl[k].ov_in_done = 1'b0;
      tbl[k].exp_done   = 11;
      tbl[k].exp_class  = 9;
      tbl[k].exp_ovr    = 1'b0;
    end
    tbl[1].stall_idx = 4;
    tbl[1].stall_len = 3;
    tbl[1].exp_done  = 14;
    tbl[2].base      = 16'hFFFC;
    for (int i = 0; i < OP_SIZE; i++) tbl[2].vals[i] = word_t'(100 - 20 * i);
    tbl[2].exp_class = 0;
    tbl[3].base      = 16'h0200;
    tbl[3].ov_cycle  = 5;
    tbl[3].exp_ovr   = 1'b1;
    for (int i = 0; i < OP_SIZE; i++) tbl[4].vals[i] = word_t'(av[i]);
    tbl[4].exp_class = 1;
    tbl[5].base       = 16'h0300;
    for (int i = 0; i < OP_SIZE; i++) tbl[5].vals[i] = word_t'(7);
    tbl[5].ov_in_done = 1'b1;
    tbl[5].exp_class  = 0;
    tbl[5].exp_ovr    = 1'b1;

    for (int k = 0; k < 6; k++) begin
      run_op(tbl[k].base, tbl[k].vals, tbl[k].stall_idx, tbl[k].stall_len, 1'b0, tbl[k].ov_cycle,
             tbl[k].ov_in_done ? tbl[k].exp_done + ARG_EXTRA : -1, dc, nw, ns, fcy);
      chk($sformatf("t%0d_done_cycle", k), 32'(dc), 32'(tbl[k].exp_done + ARG_EXTRA));
      chk($sformatf("t%0d_write_count", k), 32'(nw), 32'(OP_SIZE + ARG_EXTRA));
      chk($sformatf("t%0d_stall_cycles", k), 32'(ns), 32'(tbl[k].stall_len));
      chk($sformatf("t%0d_first_write_cycle", k), 32'(fcy), 32'd1);
      ecls = (ARG_EXTRA == 1) ? tbl[k].exp_class : 0;
      chk($sformatf("t%0d_class_idx", k), 32'(class_idx), 32'(ecls));
      idle_cycles(2, tbl[k].exp_ovr);
      chk($sformatf("t%0d_class_hold", k), 32'(class_idx), 32'(ecls));
    end

    // reset in the middle of a transfer
    for (int i = 0; i < OP_SIZE; i++) rv[i] = word_t'($urandom);
    fc_done   = 1'b1;
    base_addr = 16'h0400;
    for (int i = 0; i < OP_SIZE; i++) fc_result[i] = rv[i];
    model_push(16'h0400, rv);
    @(posedge clk);
    #1;
    fc_done = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("rst_seq_we", 32'(ram_we), 32'd1);
      pop_chk("rst_seq_write");
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_we", 32'(ram_we), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_state", 32'(dbg_state), 32'(IDLE));
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_cycles(3, 1'b0);
    for (int i = 0; i < OP_SIZE; i++) rv[i] = word_t'($urandom);
    run_op(16'h0400, rv, -1, 0, 1'b0, -1, -1, dc, nw, ns, fcy);
    chk("post_rst_done_cycle", 32'(dc), 32'(OP_SIZE + 1 + ARG_EXTRA));
    chk("post_rst_write_count", 32'(nw), 32'(OP_SIZE + ARG_EXTRA));
    idle_cycles(1, 1'b0);

    // random data, base and backpressure
    for (int r = 0; r < 10; r++) begin
      rbase = AW'($urandom);
      for (int i = 0; i < OP_SIZE; i++) rv[i] = word_t'($urandom);
      run_op(rbase, rv, -1, 0, 1'b1, -1, -1, dc, nw, ns, fcy);
      chk("rnd_done_cycle", 32'(dc), 32'(OP_SIZE + 1 + ARG_EXTRA + ns));
      chk("rnd_write_count", 32'(nw), 32'(OP_SIZE + ARG_EXTRA));
      ecls = (ARG_EXTRA == 1) ? model_argmax(rv) : 0;
      chk("rnd_class_idx", 32'(class_idx), 32'(ecls));
      idle_cycles(1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
